// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the execute stage
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_MUL = 4'b1000
  } alu_op_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  // Unused encoding 11 falls back to the register operand.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] reg_val,
                                              input logic [XLEN-1:0] wb_val,
                                              input logic [XLEN-1:0] mem_val);
    case (sel)
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

endpackage

// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - 32-iteration shift-add multiplier, low XLEN bits of the product
module iter_multiplier
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [4:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      count  <= 5'd0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start && !busy) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      count  <= 5'd0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
      if (count == 5'd31) begin
        busy <= 1'b0;
      end
    end
  end

  // High during the final iteration; product is complete after that edge.
  assign done    = busy && (count == 5'd31);
  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32 execute stage with EX/MEM register
// Optional iterative multiplier enabled by defining MUL_EN.
module execute_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rd1_e,
  input  logic [31:0] rd2_e,
  input  logic [31:0] imm_ext_e,
  input  logic [31:0] pc_e,
  input  logic [31:0] pc_plus4_e,
  input  logic [4:0]  rd_e,
  input  logic        reg_write_e,
  input  logic        mem_write_e,
  input  logic        jump_e,
  input  logic        branch_e,
  input  logic        alu_src_e,
  input  logic [1:0]  result_src_e,
  input  logic [3:0]  alu_control_e,
  input  logic [1:0]  forward_a_e,
  input  logic [1:0]  forward_b_e,
  input  logic [31:0] result_w,
  output logic [4:0]  rd_m,
  output logic [31:0] alu_result_m,
  output logic [31:0] write_data_m,
  output logic [31:0] pc_plus4_m,
  output logic        reg_write_m,
  output logic [1:0]  result_src_m,
  output logic        mem_write_m,
  output logic        pc_src_e,
  output logic [31:0] pc_target_e,
  output logic        stall_e
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] alu_out;
  logic            zero;
  alu_op_t         alu_op;

  logic [4:0]      nxt_rd;
  logic [XLEN-1:0] nxt_alu;
  logic [XLEN-1:0] nxt_wd;
  logic [XLEN-1:0] nxt_pcp4;
  logic            nxt_rw;
  logic [1:0]      nxt_rsrc;
  logic            nxt_mw;

  assign src_a      = fwd_mux(forward_a_e, rd1_e, result_w, alu_result_m);
  assign write_data = fwd_mux(forward_b_e, rd2_e, result_w, alu_result_m);
  assign src_b      = alu_src_e ? imm_ext_e : write_data;
  assign alu_op     = alu_op_t'(alu_control_e);

  // Multiply is never produced here; the iterative unit supplies it (or it reads 0).
  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD: alu_out = src_a + src_b;
      ALU_SUB: alu_out = src_a - src_b;
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_XOR: alu_out = src_a ^ src_b;
      ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_out = src_a << src_b[4:0];
      ALU_SRL: alu_out = src_a >> src_b[4:0];
      default: alu_out = '0;
    endcase
  end

  assign zero        = (alu_out == '0);
  assign pc_src_e    = jump_e | (branch_e & zero);
  assign pc_target_e = pc_e + imm_ext_e;

`ifdef MUL_EN
  mul_state_t      state;
  mul_state_t      state_nxt;
  logic            is_mul;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic            stall_raw;
  logic            bubble;
  logic [XLEN-1:0] mul_product;
  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_wd;
  logic [XLEN-1:0] hold_pcp4;
  logic            hold_rw;
  logic [1:0]      hold_rsrc;
  logic            hold_mw;

  assign is_mul = (alu_op == ALU_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    stall_raw = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (is_mul) begin
          mul_start = 1'b1;
          stall_raw = 1'b1;
          state_nxt = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        stall_raw = 1'b1;
        if (mul_done || !mul_busy) begin
          state_nxt = MUL_DONE;
        end
      end
      MUL_DONE: state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // Held mul inputs could otherwise raise stall while reset is asserted.
  assign stall_e = rst_n & stall_raw;
  assign bubble  = mul_start || (state == MUL_BUSY);

  iter_multiplier u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .op_a    (src_a),
    .op_b    (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Controls and store data are frozen at issue so forwarding churn cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_rd   <= '0;
      hold_wd   <= '0;
      hold_pcp4 <= '0;
      hold_rw   <= 1'b0;
      hold_rsrc <= '0;
      hold_mw   <= 1'b0;
    end else if (mul_start) begin
      hold_rd   <= rd_e;
      hold_wd   <= write_data;
      hold_pcp4 <= pc_plus4_e;
      hold_rw   <= reg_write_e;
      hold_rsrc <= result_src_e;
      hold_mw   <= mem_write_e;
    end
  end
`else
  assign stall_e = 1'b0;
`endif

  always_comb begin
    nxt_rd   = rd_e;
    nxt_alu  = alu_out;
    nxt_wd   = write_data;
    nxt_pcp4 = pc_plus4_e;
    nxt_rw   = reg_write_e;
    nxt_rsrc = result_src_e;
    nxt_mw   = mem_write_e;
`ifdef MUL_EN
    if (bubble) begin
      nxt_rd   = '0;
      nxt_alu  = '0;
      nxt_wd   = '0;
      nxt_pcp4 = '0;
      nxt_rw   = 1'b0;
      nxt_rsrc = '0;
      nxt_mw   = 1'b0;
    end else if (state == MUL_DONE) begin
      nxt_rd   = hold_rd;
      nxt_alu  = mul_product;
      nxt_wd   = hold_wd;
      nxt_pcp4 = hold_pcp4;
      nxt_rw   = hold_rw;
      nxt_rsrc = hold_rsrc;
      nxt_mw   = hold_mw;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      reg_write_m  <= 1'b0;
      result_src_m <= '0;
      mem_write_m  <= 1'b0;
    end else begin
      rd_m         <= nxt_rd;
      alu_result_m <= nxt_alu;
      write_data_m <= nxt_wd;
      pc_plus4_m   <= nxt_pcp4;
      reg_write_m  <= nxt_rw;
      result_src_m <= nxt_rsrc;
      mem_write_m  <= nxt_mw;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage (both MUL_EN builds)
module tb_execute_stage;

`ifdef MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
  logic [4:0]  rd_e;
  logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]  result_src_e, forward_a_e, forward_b_e;
  logic [3:0]  alu_control_e;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m, pc_target_e;
  logic        reg_write_m, mem_write_m, pc_src_e, stall_e;
  logic [1:0]  result_src_m;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .alu_control_e(alu_control_e), .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e), .result_w(result_w), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .mem_write_m(mem_write_m), .pc_src_e(pc_src_e),
    .pc_target_e(pc_target_e), .stall_e(stall_e)
  );

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pcp4, result_w;
    logic [4:0]  rd;
    logic        rw, mw, j, br, asrc;
    logic [1:0]  rsrc, fa, fb;
    logic [3:0]  op;
  } instr_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu, wd, pcp4;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw, pc_src;
    logic [31:0] tgt;
    logic        stall;
  } exp_t;

  exp_t   exp_q[$];
  instr_t cur, h, t;
  int     n_tests = 0;
  int     n_fail = 0;
  int     mul_left;
  logic [31:0] mul_prod, h_wd;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pcp4;
  logic        m_rw, m_mw;
  logic [1:0]  m_rsrc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rv, input logic [31:0] wb);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return m_alu;
    return rv;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_bubble();
    m_rd = '0; m_alu = '0; m_wd = '0; m_pcp4 = '0; m_rw = 1'b0; m_rsrc = '0; m_mw = 1'b0;
  endtask

  task automatic model_reset();
    set_bubble();
    mul_left = 0;
  endtask

  // One clock edge of the reference: a mul occupies 34 edges, the last one writes the product.
  task automatic model_edge();
    logic [31:0] a, wd, b;
    a  = fwd(cur.fa, cur.rd1, cur.result_w);
    wd = fwd(cur.fb, cur.rd2, cur.result_w);
    b  = cur.asrc ? cur.imm : wd;
    if (mul_left == 0) begin
      if (MUL_ON && cur.op == 4'd8) begin
        mul_prod = a * b;
        h = cur;
        h_wd = wd;
        mul_left = 33;
        set_bubble();
      end else begin
        m_alu = ref_alu(cur.op, a, b);
        m_rd = cur.rd; m_wd = wd; m_pcp4 = cur.pcp4;
        m_rw = cur.rw; m_rsrc = cur.rsrc; m_mw = cur.mw;
      end
    end else begin
      mul_left--;
      if (mul_left == 0) begin
        m_alu = mul_prod;
        m_rd = h.rd; m_wd = h_wd; m_pcp4 = h.pcp4;
        m_rw = h.rw; m_rsrc = h.rsrc; m_mw = h.mw;
      end else begin
        set_bubble();
      end
    end
  endtask

  task automatic drive();
    rd1_e = cur.rd1; rd2_e = cur.rd2; imm_ext_e = cur.imm; pc_e = cur.pc;
    pc_plus4_e = cur.pcp4; result_w = cur.result_w; rd_e = cur.rd;
    reg_write_e = cur.rw; mem_write_e = cur.mw; jump_e = cur.j; branch_e = cur.br;
    alu_src_e = cur.asrc; result_src_e = cur.rsrc; forward_a_e = cur.fa;
    forward_b_e = cur.fb; alu_control_e = cur.op;
  endtask

  // While the stage is stalled the instruction is held; only forwarding sources wander.
  task automatic step(input instr_t nx);
    exp_t e;
    logic [31:0] a, wd, b, res;
    @(posedge clk);
    #1;
    model_edge();
    if (mul_left == 0) begin
      cur = nx;
    end else begin
      cur.result_w = $urandom;
      cur.fa = 2'($urandom);
      cur.fb = 2'($urandom);
    end
    drive();
    a   = fwd(cur.fa, cur.rd1, cur.result_w);
    wd  = fwd(cur.fb, cur.rd2, cur.result_w);
    b   = cur.asrc ? cur.imm : wd;
    res = ref_alu(cur.op, a, b);
    e.rd = m_rd; e.alu = m_alu; e.wd = m_wd; e.pcp4 = m_pcp4;
    e.rw = m_rw; e.rsrc = m_rsrc; e.mw = m_mw;
    e.pc_src = cur.j | (cur.br & (res == 32'd0));
    e.tgt = cur.pc + cur.imm;
    e.stall = (mul_left >= 2) || (mul_left == 0 && MUL_ON && cur.op == 4'd8);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin : mon
      exp_t e;
      e = exp_q.pop_front();
      check("rd_m", 32'(rd_m), 32'(e.rd));
      check("alu_result_m", alu_result_m, e.alu);
      check("write_data_m", write_data_m, e.wd);
      check("pc_plus4_m", pc_plus4_m, e.pcp4);
      check("reg_write_m", 32'(reg_write_m), 32'(e.rw));
      check("result_src_m", 32'(result_src_m), 32'(e.rsrc));
      check("mem_write_m", 32'(mem_write_m), 32'(e.mw));
      check("pc_src_e", 32'(pc_src_e), 32'(e.pc_src));
      check("pc_target_e", pc_target_e, e.tgt);
      check("stall_e", 32'(stall_e), 32'(e.stall));
    end
  end

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic asrc);
    instr_t r;
    r = '0;
    r.op = op; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm; r.asrc = asrc;
    r.rw = 1'b1; r.rd = 5'd7; r.pcp4 = 32'h4;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.rd1 = $urandom;
    r.rd2 = ($urandom_range(0, 3) == 0) ? r.rd1 : $urandom;
    r.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
    r.pc = $urandom; r.pcp4 = r.pc + 32'd4; r.result_w = $urandom;
    r.rd = 5'($urandom); r.rw = 1'($urandom); r.mw = 1'($urandom);
    r.j = ($urandom_range(0, 7) == 0); r.br = 1'($urandom); r.asrc = 1'($urandom);
    r.rsrc = 2'($urandom); r.fa = 2'($urandom); r.fb = 2'($urandom);
    r.op = 4'($urandom_range(0, 9));
    if (r.op == 4'd8) begin
      if ($urandom_range(0, 2) != 0) r.op = 4'd0;
      r.j = 1'b0;
      r.br = 1'b0;
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_m"}, 32'(rd_m), 32'd0);
    check({tag, "_alu_result_m"}, alu_result_m, 32'd0);
    check({tag, "_write_data_m"}, write_data_m, 32'd0);
    check({tag, "_pc_plus4_m"}, pc_plus4_m, 32'd0);
    check({tag, "_reg_write_m"}, 32'(reg_write_m), 32'd0);
    check({tag, "_result_src_m"}, 32'(result_src_m), 32'd0);
    check({tag, "_mem_write_m"}, 32'(mem_write_m), 32'd0);
    check({tag, "_stall_e"}, 32'(stall_e), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cur = mk(4'd8, 32'd3, 32'd5, 32'd0, 1'b0);
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    cur = '0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;

    step(mk(4'd0, 32'd5, 32'd0, 32'd7, 1'b1));
    step(mk(4'd0, 32'h10, 32'd0, 32'd0, 1'b1));
    t = mk(4'd1, 32'd99, 32'd3, 32'd0, 1'b0); t.fa = 2'b10;
    step(t);
    t = mk(4'd0, 32'd1, 32'd50, 32'd2, 1'b1); t.fb = 2'b01; t.result_w = 32'd9; t.mw = 1'b1;
    step(t);
    t = mk(4'd1, 32'd4, 32'd4, 32'h20, 1'b0); t.br = 1'b1; t.pc = 32'h100; t.rw = 1'b0;
    step(t);
    t = mk(4'd1, 32'd4, 32'd5, 32'h20, 1'b0); t.br = 1'b1; t.pc = 32'h100; t.rw = 1'b0;
    step(t);
    t = mk(4'd8, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0); t.rd = 5'd12; t.rsrc = 2'b10;
    step(t);
    repeat (36) step('0);
    t = mk(4'd8, 32'd6, 32'd7, 32'd0, 1'b0);
    step(t);
    t = mk(4'd8, 32'h1234_5678, 32'd0, 32'h9, 1'b1);
    repeat (40) step(t);

    repeat (300) step(rand_instr());

    step(mk(4'd8, 32'd7, 32'd9, 32'd0, 1'b0));
    repeat (5) step('0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midmul_reset");
    cur = '0;
    drive();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(4'd0, 32'd5, 32'd0, 32'd7, 1'b1));
    step('0);
    repeat (30) step(rand_instr());
    repeat (40) step('0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
